// File: rtl/uart_pkg.sv
// Shared UART constants: character width and receive error-tag layout.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   // Error tag is {par, stp}
   localparam int unsigned TAG_W   = 2;
   localparam int unsigned TAG_PAR = 1;
   localparam int unsigned TAG_STP = 0;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: dual-port, synchronous write, asynchronous read.
// The array is intentionally not reset.
module uart_rx_fifo_mem #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Zero-latency read port
   assign rd_data = mem[rd_addr];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with first-word-fall-through read, sticky overrun and
// occupancy interrupt. Define UART_RX_FIFO_ERR_TAG_EN to store frames that
// fail parity/stop checks together with their {par, stp} error tag; without
// it, only error-free frames are stored and rd_err reads 2'b00.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = UART_DATA_W,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned THRESH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_W-1:0]      p_data,
   input  logic                   data_valid,
   input  logic                   done_chk,
   input  logic                   par_err,
   input  logic                   stp_err,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic [1:0]             rd_err,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overrun,
   input  logic                   ovr_clr,
   output logic                   rx_irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
   localparam int unsigned MEM_W = DATA_W + TAG_W;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             overrun_next;
   logic             wr_req;
   logic             wr_fire;
   logic             rd_fire;
   logic [MEM_W-1:0] wr_word;
   logic [MEM_W-1:0] rd_word;

`ifdef UART_RX_FIFO_ERR_TAG_EN
   logic [TAG_W-1:0] tag;
   logic             unused_dv;

   // Every checked frame is stored, tagged with its error status
   always_comb begin
      tag          = '0;
      tag[TAG_PAR] = par_err;
      tag[TAG_STP] = stp_err;
   end

   assign wr_req    = done_chk;
   assign wr_word   = {p_data, tag};
   assign rd_data   = rd_word[MEM_W-1:TAG_W];
   assign rd_err    = rd_word[TAG_W-1:0];
   assign unused_dv = data_valid;
`else
   logic unused_err;

   // Only error-free frames are stored; error frames vanish
   assign wr_req     = data_valid;
   assign wr_word    = p_data;
   assign rd_data    = rd_word;
   assign rd_err     = 2'b00;
   assign unused_err = done_chk ^ par_err ^ stp_err;
`endif

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign rd_fire = rd_en && !empty;
   assign wr_fire = wr_req && (!full || rd_fire);

   uart_rx_fifo_mem #(
      .WIDTH (MEM_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr),
      .wr_data (wr_word),
      .rd_addr (rd_ptr),
      .rd_data (rd_word)
   );

   // Next occupancy and next sticky-overrun (set beats clear)
   always_comb begin
      count_next   = count;
      overrun_next = overrun;
      if (wr_fire && !rd_fire) begin
         count_next = count + CW'(1);
      end else if (rd_fire && !wr_fire) begin
         count_next = count - CW'(1);
      end
      if (ovr_clr) begin
         overrun_next = 1'b0;
      end
      if (wr_req && !wr_fire) begin
         overrun_next = 1'b1;
      end
   end

   // Pointers, occupancy and flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
         rx_irq  <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count   <= count_next;
         overrun <= overrun_next;
         rx_irq  <= (count_next >= CW'(THRESH)) || overrun_next;
      end
   end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH  = 8;
   localparam int THRESH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] p_data = '0;
   logic       data_valid = 1'b0;
   logic       done_chk = 1'b0;
   logic       par_err = 1'b0;
   logic       stp_err = 1'b0;
   logic       rd_en = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [7:0] rd_data;
   logic [1:0] rd_err;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic       overrun;
   logic       rx_irq;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: queue of {data, par, stp}
   logic [9:0] mq[$];
   logic       m_ovr = 1'b0;
   logic       m_irq = 1'b0;

   uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .done_chk   (done_chk),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_err     (rd_err),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .overrun    (overrun),
      .ovr_clr    (ovr_clr),
      .rx_irq     (rx_irq)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic dv, input logic dc, input logic pe,
                             input logic se, input logic [7:0] d,
                             input logic rd, input logic clr);
      logic       req;
      logic       rdf;
      logic       wrf;
      logic [1:0] tag;
      logic       unused_in;
`ifdef UART_RX_FIFO_ERR_TAG_EN
      req = dc;
      tag = {pe, se};
      unused_in = dv;
`else
      req = dv;
      tag = 2'b00;
      unused_in = dc ^ pe ^ se;
`endif
      rdf = rd && (mq.size() != 0);
      wrf = req && ((mq.size() < DEPTH) || rdf);
      if (rdf) void'(mq.pop_front());
      if (wrf) mq.push_back({d, tag});
      if (req && !wrf) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_irq = (mq.size() >= THRESH) || m_ovr;
   endtask

   // One clock with the given inputs; inputs return to idle afterwards
   task automatic cycle(input logic dv, input logic dc, input logic pe,
                        input logic se, input logic [7:0] d,
                        input logic rd, input logic clr);
      data_valid = dv; done_chk = dc; par_err = pe; stp_err = se;
      p_data = d; rd_en = rd; ovr_clr = clr;
      model_step(dv, dc, pe, se, d, rd, clr);
      @(posedge clk);
      #1;
      data_valid = 1'b0; done_chk = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      rd_en = 1'b0; ovr_clr = 1'b0;
   endtask

   task automatic good_frame(input logic [7:0] d, input logic rd);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, d, rd, 1'b0);
   endtask

   task automatic pop();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({empty, full, count, overrun, rx_irq} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_flags: got e=%b f=%b c=%0d o=%b i=%b required e=1 f=0 c=0 o=0 i=0",
                  empty, full, count, overrun, rx_irq);
      end
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      good_frame(8'h41, 1'b0);
      good_frame(8'h42, 1'b0);
      good_frame(8'h43, 1'b0);
      n_checks++;
      if (count !== 4'd3 || rd_data !== 8'h41) begin
         n_fail++;
         $display("FAIL basic_fill: got count=%0d rd_data=%h required count=3 rd_data=41", count, rd_data);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rd_data !== 8'(8'h41 + i)) begin
            n_fail++;
            $display("FAIL basic_pop%0d: got %h required %h", i, rd_data, 8'(8'h41 + i));
         end
         pop();
      end
      n_checks++;
      if (empty !== 1'b1 || count !== 4'd0) begin
         n_fail++;
         $display("FAIL basic_empty: got empty=%b count=%0d required empty=1 count=0", empty, count);
      end
   endtask

   task automatic test_err_tag();
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_ERR_TAG_EN
      n_checks++;
      if (count !== 4'd1 || rd_data !== 8'h7E || rd_err !== 2'b10) begin
         n_fail++;
         $display("FAIL err_tag_stored: got count=%0d data=%h err=%b required count=1 data=7e err=10",
                  count, rd_data, rd_err);
      end
      pop();
`else
      n_checks++;
      if (count !== 4'd0 || empty !== 1'b1 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL err_dropped: got count=%0d empty=%b ovr=%b required count=0 empty=1 ovr=0",
                  count, empty, overrun);
      end
`endif
   endtask

   task automatic test_threshold();
      for (int i = 1; i <= 4; i++) begin
         good_frame(8'(8'h20 + i), 1'b0);
         n_checks++;
         if (rx_irq !== (i >= THRESH)) begin
            n_fail++;
            $display("FAIL thresh_rise%0d: got irq=%b required %b", i, rx_irq, (i >= THRESH));
         end
      end
      pop();
      n_checks++;
      if (rx_irq !== 1'b0 || count !== 4'd3) begin
         n_fail++;
         $display("FAIL thresh_fall: got irq=%b count=%0d required irq=0 count=3", rx_irq, count);
      end
      for (int i = 0; i < 3; i++) pop();
   endtask

   task automatic test_full_overrun();
      for (int i = 1; i <= 9; i++) begin
         good_frame(8'(8'h30 + i), 1'b0);
         if (i == 8) begin
            n_checks++;
            if (full !== 1'b1 || count !== 4'd8 || overrun !== 1'b0) begin
               n_fail++;
               $display("FAIL full_at8: got full=%b count=%0d ovr=%b required 1 8 0", full, count, overrun);
            end
         end
      end
      n_checks++;
      if (overrun !== 1'b1 || rx_irq !== 1'b1 || count !== 4'd8) begin
         n_fail++;
         $display("FAIL overrun_9th: got ovr=%b irq=%b count=%0d required 1 1 8", overrun, rx_irq, count);
      end
      for (int i = 1; i <= 8; i++) begin
         n_checks++;
         if (rd_data !== 8'(8'h30 + i)) begin
            n_fail++;
            $display("FAIL full_content%0d: got %h required %h", i, rd_data, 8'(8'h30 + i));
         end
         pop();
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (overrun !== 1'b0 || rx_irq !== 1'b0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_clear: got ovr=%b irq=%b empty=%b required 0 0 1", overrun, rx_irq, empty);
      end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 8; i++) good_frame(8'(8'h60 + i), 1'b0);
      n_checks++;
      if (rd_data !== 8'h60 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_head: got data=%h full=%b required 60 1", rd_data, full);
      end
      good_frame(8'h5A, 1'b1);
      n_checks++;
      if (count !== 4'd8 || overrun !== 1'b0 || rd_data !== 8'h61) begin
         n_fail++;
         $display("FAIL simul_rw: got count=%0d ovr=%b head=%h required 8 0 61", count, overrun, rd_data);
      end
      for (int i = 0; i < 7; i++) pop();
      n_checks++;
      if (rd_data !== 8'h5A || count !== 4'd1) begin
         n_fail++;
         $display("FAIL simul_tail: got data=%h count=%0d required 5a 1", rd_data, count);
      end
      pop();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 9; i++) good_frame(8'(8'h70 + i), 1'b0);
      for (int i = 0; i < 3; i++) pop();
      n_checks++;
      if (count !== 4'd5 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: got count=%0d ovr=%b required 5 1", count, overrun);
      end
      #2 rst = 1'b0;
      mq.delete();
      m_ovr = 1'b0;
      m_irq = 1'b0;
      #1;
      n_checks++;
      if (empty !== 1'b1 || count !== 4'd0 || overrun !== 1'b0 || rx_irq !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got e=%b c=%0d o=%b i=%b required 1 0 0 0", empty, count, overrun, rx_irq);
      end
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      pop();
      n_checks++;
      if (empty !== 1'b1 || count !== 4'd0) begin
         n_fail++;
         $display("FAIL rd_after_reset: got empty=%b count=%0d required 1 0", empty, count);
      end
   endtask

   task automatic test_random();
      logic [9:0] head;
      logic       dv, dc, pe, se, rd, clr;
      int         k;
      for (int n = 0; n < 400; n++) begin
         k  = $urandom_range(0, 9);
         dv = 1'b0; dc = 1'b0; pe = 1'b0; se = 1'b0;
         if (k >= 4 && k <= 7) begin
            dv = 1'b1; dc = 1'b1;
         end else if (k >= 8) begin
            dc = 1'b1;
            pe = 1'($urandom_range(0, 1));
            se = !pe || 1'($urandom_range(0, 1));
         end
         rd  = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         if (mq.size() != 0) begin
            head = mq[0];
            n_checks++;
            if (rd_data !== head[9:2] || rd_err !== head[1:0]) begin
               n_fail++;
               $display("FAIL rand_head@%0d: got %h/%b required %h/%b", n, rd_data, rd_err, head[9:2], head[1:0]);
            end
         end
         cycle(dv, dc, pe, se, 8'($urandom), rd, clr);
         n_checks++;
         if (count !== 4'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)
             || overrun !== m_ovr || rx_irq !== m_irq) begin
            n_fail++;
            $display("FAIL rand_state@%0d: got c=%0d e=%b f=%b o=%b i=%b required c=%0d o=%b i=%b",
                     n, count, empty, full, overrun, rx_irq, mq.size(), m_ovr, m_irq);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_err_tag();
      test_threshold();
      test_full_overrun();
      test_full_simul();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_rx_fifo
